// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write-side arbiter and its round-robin picker.
package fifo_arb_pkg;

  typedef enum logic [0:0] {StIdle, StGrant} arb_state_e;

  // Widest requester vector the one-hot helper can encode.
  localparam int unsigned MaxReq = 32;

  // Index width for n items; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One-hot encode of idx; callers cast the result down to their own width.
  function automatic logic [MaxReq-1:0] onehot(input int unsigned idx);
    return MaxReq'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request scanning from i_rr_last+1 with
// wrap-around, so the last winner is considered only after everyone else.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned N   = 4,
  localparam int unsigned IdW = id_width(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IdW-1:0] i_rr_last,
  output logic           o_found,
  output logic [IdW-1:0] o_pick
);

  logic [IdW-1:0] w_idx;

  // Walk the N candidates in priority order and keep the first one requesting.
  always_comb begin
    o_found = 1'b0;
    o_pick  = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = IdW'((32'(i_rr_last) + k + 1) % N);
      if (!o_found && i_req[w_idx]) begin
        o_found = 1'b1;
        o_pick  = w_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Write-side arbiter sharing the async fifo write port among N_REQ requesters using
// round-robin with a per-grant burst limit. Write fire is combinational from the
// registered grant, so a full fifo stalls with zero latency.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned D_SIZE    = 8,
  parameter  int unsigned N_REQ     = 4,
  parameter  int unsigned BURST_MAX = 4,
  localparam int unsigned IdW       = id_width(N_REQ),
  localparam int unsigned CntW      = id_width(BURST_MAX)
) (
  input  logic                    wclk,
  input  logic                    wrst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*D_SIZE-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  input  logic                    full,
  output logic                    wen,
  output logic [D_SIZE-1:0]       wdata,
  output logic                    gnt_vld,
  output logic [IdW-1:0]          gnt_id
);

  arb_state_e     r_state,     w_state_nxt;
  logic [IdW-1:0] r_gnt_id,    w_gnt_id_nxt;
  logic [IdW-1:0] r_rr_last,   w_rr_last_nxt;
  logic [CntW-1:0] r_burst_cnt, w_burst_cnt_nxt;

  logic              w_granted;
  logic              w_req_g;
  logic [D_SIZE-1:0] w_sel_data;
  logic              w_fire;
  logic              w_release;
  logic              w_found;
  logic [IdW-1:0]    w_pick;

  rr_pick #(
    .N (N_REQ)
  ) u_rr_pick (
    .i_req     (req),
    .i_rr_last (r_rr_last),
    .o_found   (w_found),
    .o_pick    (w_pick)
  );

  // Grant state; reset leaves requester 0 at top priority.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_state     <= StIdle;
      r_gnt_id    <= '0;
      r_rr_last   <= IdW'(N_REQ - 1);
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_rr_last   <= w_rr_last_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  // Rearbitrate when idle or on release; otherwise count writes within the burst.
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_id_nxt    = r_gnt_id;
    w_rr_last_nxt   = r_rr_last;
    w_burst_cnt_nxt = r_burst_cnt;
    if (r_state == StIdle || w_release) begin
      if (w_found) begin
        w_state_nxt     = StGrant;
        w_gnt_id_nxt    = w_pick;
        w_rr_last_nxt   = w_pick;
        w_burst_cnt_nxt = '0;
      end else begin
        w_state_nxt = StIdle;
      end
    end else if (w_fire) begin
      w_burst_cnt_nxt = r_burst_cnt + CntW'(1);
    end
  end

  // Select the granted requester and drive the fifo write port and handshake.
  always_comb begin
    w_granted  = (r_state == StGrant);
    w_req_g    = 1'b0;
    w_sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (IdW'(i) == r_gnt_id) begin
        w_req_g    = req[i];
        w_sel_data = req_data[i*D_SIZE +: D_SIZE];
      end
    end
    w_fire    = w_granted & w_req_g & ~full;
    // full alone never releases; only a dropped req or the last word of a burst does.
    w_release = w_granted &
                (~w_req_g | (w_fire & (r_burst_cnt == CntW'(BURST_MAX - 1))));
    wen       = w_fire;
    ack       = w_fire ? N_REQ'(onehot(32'(r_gnt_id))) : '0;
    wdata     = w_granted ? w_sel_data : '0;
    gnt_vld   = w_granted;
    gnt_id    = r_gnt_id;
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: N_REQ=4, BURST_MAX=4, D_SIZE=8.
// Inputs change and outputs are sampled in the low clock phase.
module tb_fifo_wr_arb;

  logic        wclk;
  logic        wrst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        full;
  logic        wen;
  logic [7:0]  wdata;
  logic        gnt_vld;
  logic [1:0]  gnt_id;

  int total;
  int bad;

  fifo_wr_arb #(
    .D_SIZE    (8),
    .N_REQ     (4),
    .BURST_MAX (4)
  ) dut (
    .wclk     (wclk),
    .wrst     (wrst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .full     (full),
    .wen      (wen),
    .wdata    (wdata),
    .gnt_vld  (gnt_vld),
    .gnt_id   (gnt_id)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Short asynchronous reset pulse in the low phase; the next rising edge arbitrates.
  task automatic do_reset();
    @(negedge wclk);
    wrst     = 1'b1;
    req      = '0;
    full     = 1'b0;
    req_data = '0;
    #1;
    wrst = 1'b0;
  endtask

  initial begin
    int id;
    int nw;
    logic [3:0] oh;
    logic [7:0] ed;

    total    = 0;
    bad      = 0;
    wrst     = 1'b1;
    req      = '0;
    full     = 1'b0;
    req_data = '0;

    // 1) reset state, then first grant and first write.
    repeat (2) @(negedge wclk);
    chk("rst_gnt_vld", 32'(gnt_vld), 0);
    chk("rst_wen", 32'(wen), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_wdata", 32'(wdata), 0);
    chk("rst_gnt_id", 32'(gnt_id), 0);
    wrst          = 1'b0;
    req           = 4'b0001;
    req_data[7:0] = 8'hA5;
    @(negedge wclk);
    chk("t1_gnt_vld", 32'(gnt_vld), 1);
    chk("t1_gnt_id", 32'(gnt_id), 0);
    chk("t1_wen", 32'(wen), 1);
    chk("t1_wdata", 32'(wdata), 32'h A5);
    chk("t1_ack", 32'(ack), 32'b0001);

    // 2) all request: 4-word bursts in order 0,1,2,3,0 with no idle cycles.
    do_reset();
    req_data = {8'h30, 8'h20, 8'h10, 8'h00};
    req      = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      @(negedge wclk);
      id = (k / 4) % 4;
      oh = 4'b0001 << id;
      ed = 8'(id * 16 + (k / 16) * 4 + (k % 4));
      chk("t2_wen", 32'(wen), 1);
      chk("t2_gnt_id", 32'(gnt_id), 32'(id));
      chk("t2_ack", 32'(ack), 32'(oh));
      chk("t2_wdata", 32'(wdata), 32'(ed));
      req_data[id*8 +: 8] = req_data[id*8 +: 8] + 8'd1;
    end

    // 3) full stalls requester 0 for 3 cycles after its 2nd write; burst count is held.
    do_reset();
    req_data = {8'h00, 8'h20, 8'h00, 8'h10};
    req      = 4'b0101;
    @(negedge wclk);
    chk("t3_w1_wen", 32'(wen), 1);
    chk("t3_w1_gnt", 32'(gnt_id), 0);
    @(negedge wclk);
    chk("t3_w2_wen", 32'(wen), 1);
    @(negedge wclk);
    full = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) @(negedge wclk);
      chk("t3_stall_wen", 32'(wen), 0);
      chk("t3_stall_ack", 32'(ack), 0);
      chk("t3_stall_gnt", 32'(gnt_id), 0);
      chk("t3_stall_vld", 32'(gnt_vld), 1);
    end
    @(negedge wclk);
    full = 1'b0;
    #1;
    chk("t3_w3_wen", 32'(wen), 1);
    chk("t3_w3_gnt", 32'(gnt_id), 0);
    @(negedge wclk);
    chk("t3_w4_wen", 32'(wen), 1);
    chk("t3_w4_gnt", 32'(gnt_id), 0);
    @(negedge wclk);
    chk("t3_next_gnt", 32'(gnt_id), 2);
    chk("t3_next_wen", 32'(wen), 1);
    chk("t3_next_wdata", 32'(wdata), 32'h20);

    // 4) requester 1 drops req after 2 acks; grant moves to 3.
    do_reset();
    req_data = {8'h33, 8'h00, 8'h31, 8'h00};
    req      = 4'b1010;
    @(negedge wclk);
    chk("t4_w1_gnt", 32'(gnt_id), 1);
    chk("t4_w1_ack", 32'(ack), 32'b0010);
    @(negedge wclk);
    chk("t4_w2_ack", 32'(ack), 32'b0010);
    @(negedge wclk);
    req = 4'b1000;
    #1;
    chk("t4_drop_wen", 32'(wen), 0);
    chk("t4_drop_ack", 32'(ack), 0);
    chk("t4_drop_gnt", 32'(gnt_id), 1);
    @(negedge wclk);
    chk("t4_next_gnt", 32'(gnt_id), 3);
    chk("t4_next_wen", 32'(wen), 1);
    chk("t4_next_wdata", 32'(wdata), 32'h33);
    chk("t4_next_ack", 32'(ack), 32'b1000);
    // Only requester 1, which then drops: back to idle.
    do_reset();
    req_data = {8'h00, 8'h00, 8'h41, 8'h00};
    req      = 4'b0010;
    @(negedge wclk);
    chk("t4b_wen", 32'(wen), 1);
    chk("t4b_gnt", 32'(gnt_id), 1);
    req = 4'b0000;
    #1;
    chk("t4b_drop_wen", 32'(wen), 0);
    chk("t4b_drop_vld", 32'(gnt_vld), 1);
    @(negedge wclk);
    chk("t4b_idle_vld", 32'(gnt_vld), 0);
    chk("t4b_idle_wen", 32'(wen), 0);

    // 5) lone streaming requester: 16 back-to-back writes across rearbitrations.
    do_reset();
    req_data = {8'h00, 8'h00, 8'h00, 8'h5A};
    req      = 4'b0001;
    nw       = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge wclk);
      chk("t5_wen", 32'(wen), 1);
      chk("t5_vld", 32'(gnt_vld), 1);
      if (wen && gnt_id == 2'd0) nw++;
    end
    chk("t5_writes", 32'(nw), 16);

    // 6) asynchronous reset mid-burst from requester 2; first grant afterwards goes to 0.
    do_reset();
    req_data = {8'h00, 8'h77, 8'h00, 8'h00};
    req      = 4'b0100;
    @(negedge wclk);
    chk("t6_gnt", 32'(gnt_id), 2);
    chk("t6_wdata", 32'(wdata), 32'h77);
    @(negedge wclk);
    chk("t6_wen", 32'(wen), 1);
    #2;
    wrst = 1'b1;
    #1;
    chk("t6_rst_wen", 32'(wen), 0);
    chk("t6_rst_ack", 32'(ack), 0);
    chk("t6_rst_vld", 32'(gnt_vld), 0);
    chk("t6_rst_wdata", 32'(wdata), 0);
    req           = 4'b0101;
    req_data[7:0] = 8'h11;
    @(negedge wclk);
    wrst = 1'b0;
    @(negedge wclk);
    chk("t6_post_gnt", 32'(gnt_id), 0);
    chk("t6_post_wen", 32'(wen), 1);
    chk("t6_post_wdata", 32'(wdata), 32'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
